// File: rtl/dfr_pkg.sv
// -----------------------------------------------------------------------------
// dfr_pkg
// Shared definitions for the DFR core.
//   - dfr_state_t / ST_*  : readout FSM state encoding (3-bit legacy constants)
//   - ACC_GUARD_W         : extra accumulator bits above the full product width
//   - SAT_MAX_W           : widest value sat_trunc accepts
//   - sat_trunc()         : signed saturating truncation, also used by the
//                           reservoir node output path
// -----------------------------------------------------------------------------
package dfr_pkg;

  typedef logic [2:0] dfr_state_t;

  localparam dfr_state_t ST_IDLE  = 3'd0;
  localparam dfr_state_t ST_ISSUE = 3'd1;
  localparam dfr_state_t ST_DRAIN = 3'd2;
  localparam dfr_state_t ST_WRITE = 3'd3;
  localparam dfr_state_t ST_DONE  = 3'd4;

  localparam int ACC_GUARD_W = 8;

  // Callers sign-extend into this width and cast the result down to out_w.
  // Supports out_w up to SAT_MAX_W and accumulators up to SAT_MAX_W bits.
  localparam int SAT_MAX_W = 128;

  // Clamp a signed value to the range of a signed out_w-bit number. The
  // result is still SAT_MAX_W wide; only its low out_w bits are meaningful.
  function automatic logic signed [SAT_MAX_W-1:0] sat_trunc(
    input logic signed [SAT_MAX_W-1:0] val,
    input int unsigned                 out_w
  );
    logic signed [SAT_MAX_W-1:0] one;
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    one   = SAT_MAX_W'(1);
    max_v = (one << (out_w - 1)) - one;
    // Two's complement: the most negative value is the bitwise inverse of
    // the most positive one.
    min_v = ~max_v;
    if (val > max_v) begin
      return max_v;
    end else if (val < min_v) begin
      return min_v;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/dfr_mac_pipe.sv
// -----------------------------------------------------------------------------
// dfr_mac_pipe
// Two registered stages of signed multiply/accumulate.
//   Stage 2: prod  <= a * b                      (2*W bits, signed)
//   Stage 3: acc   <= first ? prod : acc + prod  (ACC_W bits, sign-extended)
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   a, b         : signed operands, qualified by valid
//   valid        : operand beat present this cycle
//   first        : this beat starts a new dot product (clears the sum)
//   acc          : running accumulator
//   acc_valid    : acc was updated by a beat on the previous edge
// Handshake: valid is a pure qualifier with no ready; every valid beat is
// consumed in the cycle it is presented, and the pipe never stalls.
// -----------------------------------------------------------------------------
module dfr_mac_pipe #(
  parameter int W     = 32,
  parameter int ACC_W = 2 * W + 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  input  logic                    valid,
  input  logic                    first,
  output logic signed [ACC_W-1:0] acc,
  output logic                    acc_valid
);

  logic signed [2*W-1:0] prod;
  logic                  prod_valid;
  logic                  prod_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
    end else begin
      prod_valid <= valid;
      prod_first <= first;
      if (valid) begin
        prod <= a * b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= prod_valid;
      if (prod_valid) begin
        // Loading instead of adding on the first beat clears the previous
        // sample's sum without an extra cycle.
        if (prod_first) begin
          acc <= ACC_W'(prod);
        end else begin
          acc <= acc + ACC_W'(prod);
        end
      end
    end
  end

endmodule

// File: rtl/dfr_readout_mac.sv
// -----------------------------------------------------------------------------
// dfr_readout_mac
// Readout stage of the DFR core. On start, walks num_samples consecutive
// reservoir samples of NUM_VIRTUAL_NODES states each, forms the dot product
// of every sample with the trained weight vector and writes the saturated
// result to the output memory at address = sample index.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : launch pulse (ignored unless idle)
//   num_samples           : samples to process, captured on start
//   sample_base           : reservoir address of the first node, captured on start
//   res_addr / res_rdata  : reservoir read port, 1-cycle latency
//   wgt_addr / wgt_rdata  : weight read port, 1-cycle latency
//   out_addr / out_wdata / out_wen : output memory write port
//   busy                  : a run is in progress
//   done                  : one-cycle completion pulse
//   state_dbg             : current FSM state (dfr_pkg ST_* encoding)
// Per sample: NUM_VIRTUAL_NODES ISSUE cycles, 2 DRAIN cycles, 1 WRITE cycle.
// -----------------------------------------------------------------------------
module dfr_readout_mac
  import dfr_pkg::*;
#(
  parameter int NUM_VIRTUAL_NODES            = 100,
  parameter int RESERVOIR_DATA_WIDTH         = 32,
  parameter int RESERVOIR_HISTORY_ADDR_WIDTH = 17,
  parameter int OUTPUT_ADDR_WIDTH            = 17,
  parameter int ACC_SHIFT                    = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [31:0]                             num_samples,
  input  logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] sample_base,
  output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] res_addr,
  input  logic [RESERVOIR_DATA_WIDTH-1:0]         res_rdata,
  output logic [$clog2(NUM_VIRTUAL_NODES)-1:0]    wgt_addr,
  input  logic [RESERVOIR_DATA_WIDTH-1:0]         wgt_rdata,
  output logic [OUTPUT_ADDR_WIDTH-1:0]            out_addr,
  output logic [RESERVOIR_DATA_WIDTH-1:0]         out_wdata,
  output logic                                    out_wen,
  output logic                                    busy,
  output logic                                    done,
  output logic [2:0]                              state_dbg
);

  localparam int W     = RESERVOIR_DATA_WIDTH;
  localparam int RAW   = RESERVOIR_HISTORY_ADDR_WIDTH;
  localparam int NAW   = $clog2(NUM_VIRTUAL_NODES);
  localparam int ACC_W = 2 * W + ACC_GUARD_W;

  dfr_state_t            state;
  logic [NAW-1:0]        node_cnt;
  logic                  drain_cnt;
  logic [RAW-1:0]        res_ptr;
  logic [31:0]           sample_cnt;
  logic [31:0]           num_q;
  logic [OUTPUT_ADDR_WIDTH-1:0] out_idx;

  // Read data returns one cycle after the address, so the beat qualifiers
  // are the ISSUE-state flags delayed by one cycle.
  logic                  beat_valid;
  logic                  beat_first;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_shifted;
  logic                    acc_valid;

  // ---------------------------------------------------------------------------
  // FSM and address counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      node_cnt   <= '0;
      drain_cnt  <= 1'b0;
      res_ptr    <= '0;
      sample_cnt <= '0;
      num_q      <= '0;
      out_idx    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_q      <= num_samples;
            res_ptr    <= sample_base;
            sample_cnt <= '0;
            out_idx    <= '0;
            node_cnt   <= '0;
            state      <= (num_samples == 32'd0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The pointer runs on across samples and wraps naturally, so
          // sample s node n lands on base + s*N + n without a multiplier.
          res_ptr <= res_ptr + RAW'(1);
          if (node_cnt == NAW'(NUM_VIRTUAL_NODES - 1)) begin
            node_cnt  <= '0;
            drain_cnt <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            node_cnt <= node_cnt + NAW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state <= ST_WRITE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_WRITE: begin
          out_idx    <= out_idx + OUTPUT_ADDR_WIDTH'(1);
          sample_cnt <= sample_cnt + 32'd1;
          if ((sample_cnt + 32'd1) == num_q) begin
            state <= ST_DONE;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_valid <= 1'b0;
      beat_first <= 1'b0;
    end else begin
      beat_valid <= (state == ST_ISSUE);
      beat_first <= (state == ST_ISSUE) && (node_cnt == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply/accumulate pipeline
  // ---------------------------------------------------------------------------
  dfr_mac_pipe #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac_pipe (
    .clk       (clk),
    .rst       (rst),
    .a         (res_rdata),
    .b         (wgt_rdata),
    .valid     (beat_valid),
    .first     (beat_first),
    .acc       (acc),
    .acc_valid (acc_valid)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign acc_shifted = acc >>> ACC_SHIFT;

  // The accumulator resets to zero, so out_wdata is zero out of reset and
  // immediately on a mid-run reset.
  assign out_wdata = W'(sat_trunc(SAT_MAX_W'(acc_shifted), W));

  // The last node's product reaches the accumulator on the edge entering
  // WRITE, so acc_valid is always high here; it guards against writing a
  // sum that never received a beat.
  assign out_wen   = (state == ST_WRITE) && acc_valid;
  assign out_addr  = out_idx;
  assign res_addr  = res_ptr;
  assign wgt_addr  = node_cnt;
  assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN) || (state == ST_WRITE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_dfr_readout_mac.sv
// -----------------------------------------------------------------------------
// tb_dfr_readout_mac
// Directed table-driven bench for dfr_readout_mac with behavioural 1-cycle
// reservoir and weight memories, plus hand-written reset sequences.
// -----------------------------------------------------------------------------
module tb_dfr_readout_mac;

  localparam int N      = 100;
  localparam int DW     = 32;
  localparam int RAW    = 17;
  localparam int OAW    = 17;
  localparam int WAW    = $clog2(N);
  localparam int SCYC   = N + 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [31:0]     num_samples = '0;
  logic [RAW-1:0]  sample_base = '0;
  logic [RAW-1:0]  res_addr;
  logic [DW-1:0]   res_rdata = '0;
  logic [WAW-1:0]  wgt_addr;
  logic [DW-1:0]   wgt_rdata = '0;
  logic [OAW-1:0]  out_addr;
  logic [DW-1:0]   out_wdata;
  logic            out_wen;
  logic            busy;
  logic            done;
  logic [2:0]      state_dbg;

  dfr_readout_mac #(
    .NUM_VIRTUAL_NODES            (N),
    .RESERVOIR_DATA_WIDTH         (DW),
    .RESERVOIR_HISTORY_ADDR_WIDTH (RAW),
    .OUTPUT_ADDR_WIDTH            (OAW),
    .ACC_SHIFT                    (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .sample_base (sample_base),
    .res_addr    (res_addr),
    .res_rdata   (res_rdata),
    .wgt_addr    (wgt_addr),
    .wgt_rdata   (wgt_rdata),
    .out_addr    (out_addr),
    .out_wdata   (out_wdata),
    .out_wen     (out_wen),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // Behavioural memories: registered read, 1-cycle latency.
  logic [DW-1:0] res_mem [0:(1<<RAW)-1];
  logic [DW-1:0] wgt_mem [0:N-1];

  always @(posedge clk) begin
    res_rdata <= res_mem[res_addr];
    wgt_rdata <= wgt_mem[wgt_addr];
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string         name;
    int unsigned   nsamp;
    logic [RAW-1:0] base;
    logic [DW-1:0] st_val;      // state value of sample 0
    logic [DW-1:0] st_step;     // added per sample index
    logic          wgt_ramp;    // 1: weight n = n - 50
    logic [DW-1:0] wgt_val;     // constant weight when not ramped
    int            restart_at;  // cycle of an extra start pulse (0 = none)
    logic [DW-1:0] exp_data [3];
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs [NVEC];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input vec_t v);
    for (int s = 0; s < int'(v.nsamp); s++) begin
      for (int n = 0; n < N; n++) begin
        res_mem[RAW'(int'(v.base) + s * N + n)] = v.st_val + v.st_step * DW'(s);
      end
    end
    for (int n = 0; n < N; n++) begin
      wgt_mem[n] = v.wgt_ramp ? DW'(n - 50) : v.wgt_val;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [DW-1:0]  exp_q [$];
    logic [DW-1:0]  got_d_q [$];
    logic [OAW-1:0] got_a_q [$];
    int             got_r_q [$];
    int             budget, run_len, addr_err, busy_err, n_done, done_rel, k, s;
    logic           exp_busy;
    logic [RAW-1:0] exp_ra;

    fill_mem(v);
    for (int i = 0; i < int'(v.nsamp); i++) exp_q.push_back(v.exp_data[i]);

    run_len  = int'(v.nsamp) * SCYC;
    budget   = run_len + 8;
    addr_err = 0;
    busy_err = 0;
    n_done   = 0;
    done_rel = -1;

    @(negedge clk);
    num_samples = v.nsamp;
    sample_base = v.base;
    start       = 1'b1;

    for (int rel = 1; rel <= budget; rel++) begin
      @(negedge clk);
      exp_busy = (rel <= run_len);
      if (busy !== exp_busy) busy_err++;
      if (rel <= run_len) begin
        s = (rel - 1) / SCYC;
        k = (rel - 1) % SCYC;
        if (k < N) begin
          exp_ra = RAW'(int'(v.base) + s * N + k);
          if (res_addr !== exp_ra || wgt_addr !== WAW'(k)) addr_err++;
        end
      end
      if (out_wen === 1'b1) begin
        got_d_q.push_back(out_wdata);
        got_a_q.push_back(out_addr);
        got_r_q.push_back(rel);
      end
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) done_rel = rel;
      end
      // An extra start with different arguments must be ignored while busy.
      if (v.restart_at != 0 && rel == v.restart_at) begin
        start       = 1'b1;
        num_samples = 32'd7;
        sample_base = '0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;

    chk({v.name, " busy_window_errors"}, 64'(busy_err), 64'd0);
    chk({v.name, " addr_seq_errors"},    64'(addr_err), 64'd0);
    chk({v.name, " done_pulses"},        64'(n_done),   64'd1);
    chk({v.name, " done_cycle"},         64'(done_rel), 64'(run_len + 1));
    chk({v.name, " write_count"},        64'(got_d_q.size()), 64'(v.nsamp));
    for (int i = 0; i < got_d_q.size(); i++) begin
      if (exp_q.size() > 0) begin
        chk($sformatf("%s wdata[%0d]", v.name, i), 64'(got_d_q[i]), 64'(exp_q.pop_front()));
      end
      chk($sformatf("%s waddr[%0d]", v.name, i), 64'(got_a_q[i]), 64'(i));
      chk($sformatf("%s wcycle[%0d]", v.name, i), 64'(got_r_q[i]), 64'((i + 1) * SCYC));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " res_addr"},  64'(res_addr),  64'd0);
    chk({tag, " wgt_addr"},  64'(wgt_addr),  64'd0);
    chk({tag, " out_addr"},  64'(out_addr),  64'd0);
    chk({tag, " out_wdata"}, 64'(out_wdata), 64'd0);
    chk({tag, " ctrl"},      64'({out_wen, busy, done}), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int wen_seen;

    for (int i = 0; i < (1 << RAW); i++) res_mem[i] = '0;
    for (int i = 0; i < N; i++) wgt_mem[i] = '0;

    //               name          ns base          st_val        step wr  wgt_val       rs   expected
    vecs[0] = '{"single",      1, 17'd0,      32'd1,        32'd0, 1'b0, 32'd2,        0,
                '{32'd200, 32'd0, 32'd0}};
    vecs[1] = '{"sign_order",  1, 17'd1000,   32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0,       0,
                '{32'd50, 32'd0, 32'd0}};
    vecs[2] = '{"sat_pos",     1, 17'd5000,   32'h7FFF_FFFF, 32'd0, 1'b0, 32'h7FFF_FFFF, 0,
                '{32'h7FFF_FFFF, 32'd0, 32'd0}};
    vecs[3] = '{"sat_neg",     1, 17'd6000,   32'h7FFF_FFFF, 32'd0, 1'b0, 32'h8000_0001, 0,
                '{32'h8000_0000, 32'd0, 32'd0}};
    // Base 2^17-150: sample 1 wraps to address 0 at its node 50.
    vecs[4] = '{"multi_wrap",  3, 17'd130922, 32'd1,        32'd1, 1'b0, 32'd1,        150,
                '{32'd100, 32'd200, 32'd300}};
    vecs[5] = '{"zero",        0, 17'd0,      32'd0,        32'd0, 1'b0, 32'd0,        0,
                '{32'd0, 32'd0, 32'd0}};

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", 64'(busy), 64'd0);

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Reset at node 40 of sample 0, then a fresh run
    fill_mem(vecs[0]);
    @(negedge clk);
    num_samples = 32'd1;
    sample_base = 17'd0;
    start       = 1'b1;
    wen_seen    = 0;
    for (int rel = 1; rel <= 41; rel++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_wen === 1'b1) wen_seen++;
    end
    chk("midrun res_addr node40", 64'(res_addr), 64'd40);
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    repeat (2) begin
      @(negedge clk);
      if (out_wen === 1'b1) wen_seen++;
    end
    rst = 1'b0;
    repeat (SCYC + 5) begin
      @(negedge clk);
      if (out_wen === 1'b1 || busy === 1'b1) wen_seen++;
    end
    chk("reset no write/busy", 64'(wen_seen), 64'd0);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
